mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Single-port memory controller and arbiter for the five-stage core. It shares one byte-wide synchronous RAM port between the instruction-fetch requester (pc/if_id side) and the memory-stage requester (mm). It serialises each 8/16/32-bit access into byte cycles and returns assembled little-endian words with a one-cycle completion pulse.

## Interface
- ADDR_W, 32, address width of requester and RAM addresses
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request; held high until if_done
- if_addr  in  ADDR_W  fetch byte address (4-byte read)
- if_data  out  32  fetched instruction, valid while if_done
- if_done  out  1  one-cycle completion pulse for fetch
- mm_req  in  1  memory-stage request; held high until mm_done
- mm_we  in  1  1 = write, 0 = read
- mm_len  in  2  access size: 0 = byte, 1 = half, 3 = word (2 is illegal and treated as word)
- mm_addr  in  ADDR_W  byte address; any alignment is legal
- mm_wdata  in  32  write data, low bytes used
- mm_rdata  out  32  zero-extended read data, valid while mm_done
- mm_done  out  1  one-cycle completion pulse for memory stage
- ram_din  in  8  RAM read byte, valid the cycle after its address
- ram_addr  out  ADDR_W  RAM byte address
- ram_dout  out  8  RAM write byte
- ram_we  out  1  RAM write strobe
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, RD, WR, DONE. Owner register: IF or MM.
- IDLE: arbitration uses fixed priority. mm_req beats if_req; MM then IF cannot starve IF, because each MM access needs a prior fetch.
  - On accept, latch owner, addr, N = len+1 bytes (N = 4 for IF), wdata, and direction.
  - Go to RD or WR with cnt = 0.
- Requester inputs are ignored outside IDLE.
- WR: ram_we = 1, ram_addr = addr+cnt, ram_dout = wdata byte cnt.
  - Increment cnt each cycle.
  - After byte N-1, go to DONE.
- RD: in cycle k (k = 1..N+1 after accept), ram_addr = addr+(k-1) while k ≤ N.
  - ram_din in cycle k+1 carries byte k-1 and is shifted into the data register at position k-1.
  - After capturing byte N-1, go to DONE.
- DONE: the owner's done = 1 and its data output holds the assembled value. Unused upper bytes are 0.
  - Always go to IDLE next; no accept happens in DONE.
- Address arithmetic is modulo 2^ADDR_W: 0xFFFFFFFF+1 wraps to 0.
- Byte order is little-endian. Byte 0 goes to / comes from the lowest address.
- ram_addr/ram_we/ram_dout are functions of registered state only, with no combinational path from request inputs.
- Outside WR, ram_we = 0. In IDLE/DONE, ram_addr = 0 and ram_dout = 0.
- Reset, asynchronous, at any time:
  - state IDLE; all outputs 0.
  - An aborted write leaves already-written bytes in RAM.
  - No done pulse is generated for the aborted access.

## Timing
- Cycle numbering: cycle 1 is the first cycle after the accepting edge.
- Write of N bytes: ram_we high in cycles 1..N; done in cycle N+1. Word = 5, half = 3, byte = 2.
- Read of N bytes: addresses in cycles 1..N; done in cycle N+2. Word = 6, half = 4, byte = 3.
- Earliest next accept is at the edge ending cycle (done+1), i.e. the IDLE cycle after DONE.
- The requester may drop req in the cycle after done, or keep it high for a new access. That new access is accepted at the edge ending the IDLE cycle.
- Simultaneous if_req and mm_req at the same edge: MM is served; IF waits with if_req held.

## Structure
- Shared package risc_pkg holds:
  - len encodings LEN_B = 2'd0, LEN_H = 2'd1, LEN_W = 2'd3;
  - owner encodings OWN_IF / OWN_MM;
  - the mem_ctrl state enum (IDLE, RD, WR, DONE).
- No sub-module. The byte counter, address incrementer and assembly shifter are small and stay inline.

## Test plan
- IF word read at 0x1000, RAM 0x1000..3 = 11,22,33,44:
  - ram_addr 0x1000..0x1003 in cycles 1–4;
  - if_done only in cycle 6 with if_data = 0x44332211;
  - busy low in cycle 7.
- if_req and mm_req (word read) rise together:
  - mm_done in cycle 6;
  - IF accepted at end of cycle 7; if_done in cycle 13.
- MM half write 0x0000BEEF at 0x2001:
  - ram_we in cycles 1–2 with addr/data 0x2001/EF, then 0x2002/BE;
  - mm_done in cycle 3; ram_we 0 afterward.
- MM byte read at 0x3003, RAM byte 0x9C:
  - mm_rdata = 0x0000009C, mm_done in cycle 3.
- MM word read at 0xFFFFFFFE:
  - ram_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- rst asserted in cycle 3 of a word write:
  - ram_we drops immediately and busy = 0;
  - no mm_done; only 2 bytes written;
  - after release, a new request completes normally.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the core: access-length codes, memory owner codes,
// the memory controller state encoding and small byte helpers.
package risc_pkg;

  // Access length encodings (number of bytes minus one; 2'd2 is illegal)
  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd3;

  // Owner of the in-flight RAM access
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_MM = 1'b1;

  // Memory controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } mem_ctrl_state_e;

  // Index of the last byte of an access; the illegal length 2 is treated as a word
  function automatic logic [1:0] len_last(input logic [1:0] len);
    logic [1:0] last;
    case (len)
      LEN_B:   last = 2'd0;
      LEN_H:   last = 2'd1;
      LEN_W:   last = 2'd3;
      default: last = 2'd3;
    endcase
    return last;
  endfunction

  // Little-endian byte lane select from a 32-bit word
  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'd0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Single-port byte-wide RAM controller shared by instruction fetch and the
// memory stage. Serialises 1/2/4-byte accesses into byte cycles, assembles
// little-endian read data and pulses the owner's done for one cycle.
// All RAM-side and requester-side outputs come straight from registers.
module mem_ctrl
  import risc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mm_req,
  input  logic              mm_we,
  input  logic [1:0]        mm_len,
  input  logic [ADDR_W-1:0] mm_addr,
  input  logic [31:0]       mm_wdata,
  output logic [31:0]       mm_rdata,
  output logic              mm_done,
  input  logic [7:0]        ram_din,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  output logic              ram_we,
  output logic              busy
);

  // Control / datapath state
  mem_ctrl_state_e   state_r;
  logic              owner_r;
  logic [ADDR_W-1:0] addr_r;
  logic [1:0]        last_r;
  logic [2:0]        cnt_r;
  logic [31:0]       wdata_r;
  logic [31:0]       asm_r;

  // Output registers
  logic [ADDR_W-1:0] ram_addr_r;
  logic [7:0]        ram_dout_r;
  logic              ram_we_r;
  logic              if_done_r;
  logic              mm_done_r;
  logic [31:0]       if_data_r;
  logic [31:0]       mm_rdata_r;
  logic              busy_r;

  // Next-state values
  mem_ctrl_state_e   nxt_state_s;
  logic              nxt_owner_s;
  logic [ADDR_W-1:0] nxt_addr_s;
  logic [1:0]        nxt_last_s;
  logic [2:0]        nxt_cnt_s;
  logic [31:0]       nxt_wdata_s;
  logic [31:0]       nxt_asm_s;
  logic [ADDR_W-1:0] nxt_ram_addr_s;
  logic [7:0]        nxt_ram_dout_s;
  logic              nxt_ram_we_s;
  logic              nxt_if_done_s;
  logic              nxt_mm_done_s;
  logic [31:0]       nxt_if_data_s;
  logic [31:0]       nxt_mm_rdata_s;
  logic              nxt_busy_s;

  // Read assembly: the byte on ram_din now belongs to the address issued
  // one cycle earlier, i.e. byte lane cnt_r-1.
  logic [1:0]  lane_s;
  logic [31:0] captured_s;

  assign lane_s     = cnt_r[1:0] - 2'd1;
  assign captured_s = asm_r | ({24'd0, ram_din} << {lane_s, 3'b000});

  // Arbitration, byte sequencing and next values for every registered output
  always_comb begin
    nxt_state_s    = state_r;
    nxt_owner_s    = owner_r;
    nxt_addr_s     = addr_r;
    nxt_last_s     = last_r;
    nxt_cnt_s      = cnt_r;
    nxt_wdata_s    = wdata_r;
    nxt_asm_s      = asm_r;
    nxt_ram_addr_s = '0;
    nxt_ram_dout_s = 8'd0;
    nxt_ram_we_s   = 1'b0;
    nxt_if_done_s  = 1'b0;
    nxt_mm_done_s  = 1'b0;
    nxt_if_data_s  = 32'd0;
    nxt_mm_rdata_s = 32'd0;

    case (state_r)
      ST_IDLE: begin
        // Fixed priority: the memory stage beats fetch
        if (mm_req) begin
          nxt_owner_s    = OWN_MM;
          nxt_addr_s     = mm_addr;
          nxt_last_s     = len_last(mm_len);
          nxt_wdata_s    = mm_wdata;
          nxt_cnt_s      = 3'd0;
          nxt_asm_s      = 32'd0;
          nxt_ram_addr_s = mm_addr;
          if (mm_we) begin
            nxt_state_s    = ST_WR;
            nxt_ram_we_s   = 1'b1;
            nxt_ram_dout_s = mm_wdata[7:0];
          end else begin
            nxt_state_s = ST_RD;
          end
        end else if (if_req) begin
          nxt_owner_s    = OWN_IF;
          nxt_addr_s     = if_addr;
          nxt_last_s     = LEN_W;
          nxt_wdata_s    = 32'd0;
          nxt_cnt_s      = 3'd0;
          nxt_asm_s      = 32'd0;
          nxt_ram_addr_s = if_addr;
          nxt_state_s    = ST_RD;
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end

      ST_WR: begin
        // cnt_r is the byte currently on the RAM port
        if (cnt_r[1:0] == last_r) begin
          nxt_state_s = ST_DONE;
          if (owner_r == OWN_MM) begin
            nxt_mm_done_s = 1'b1;
          end else begin
            nxt_if_done_s = 1'b1;
          end
        end else begin
          nxt_cnt_s      = cnt_r + 3'd1;
          nxt_ram_we_s   = 1'b1;
          nxt_ram_addr_s = addr_r + ADDR_W'(cnt_r + 3'd1);
          nxt_ram_dout_s = get_byte(wdata_r, cnt_r[1:0] + 2'd1);
        end
      end

      ST_RD: begin
        // cnt_r counts read cycles since accept (cycle k has cnt_r = k-1)
        nxt_cnt_s = cnt_r + 3'd1;
        if (cnt_r != 3'd0) begin
          nxt_asm_s = captured_s;
        end else begin
          nxt_asm_s = asm_r;
        end
        if (cnt_r < {1'b0, last_r}) begin
          nxt_ram_addr_s = addr_r + ADDR_W'(cnt_r + 3'd1);
        end else begin
          nxt_ram_addr_s = '0;
        end
        if (cnt_r == ({1'b0, last_r} + 3'd1)) begin
          nxt_state_s = ST_DONE;
          if (owner_r == OWN_MM) begin
            nxt_mm_done_s  = 1'b1;
            nxt_mm_rdata_s = captured_s;
          end else begin
            nxt_if_done_s = 1'b1;
            nxt_if_data_s = captured_s;
          end
        end else begin
          nxt_state_s = ST_RD;
        end
      end

      ST_DONE: begin
        // No accept here: the requester gets one IDLE cycle to drop req
        nxt_state_s = ST_IDLE;
        nxt_cnt_s   = 3'd0;
      end

      default: begin
        nxt_state_s = ST_IDLE;
        nxt_cnt_s   = 3'd0;
      end
    endcase

    nxt_busy_s = (nxt_state_s != ST_IDLE);
  end

  // Control and datapath state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      owner_r <= OWN_IF;
      addr_r  <= '0;
      last_r  <= 2'd0;
      cnt_r   <= 3'd0;
      wdata_r <= 32'd0;
      asm_r   <= 32'd0;
    end else begin
      state_r <= nxt_state_s;
      owner_r <= nxt_owner_s;
      addr_r  <= nxt_addr_s;
      last_r  <= nxt_last_s;
      cnt_r   <= nxt_cnt_s;
      wdata_r <= nxt_wdata_s;
      asm_r   <= nxt_asm_s;
    end
  end

  // Output registers; reset clears every output immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_addr_r <= '0;
      ram_dout_r <= 8'd0;
      ram_we_r   <= 1'b0;
      if_done_r  <= 1'b0;
      mm_done_r  <= 1'b0;
      if_data_r  <= 32'd0;
      mm_rdata_r <= 32'd0;
      busy_r     <= 1'b0;
    end else begin
      ram_addr_r <= nxt_ram_addr_s;
      ram_dout_r <= nxt_ram_dout_s;
      ram_we_r   <= nxt_ram_we_s;
      if_done_r  <= nxt_if_done_s;
      mm_done_r  <= nxt_mm_done_s;
      if_data_r  <= nxt_if_data_s;
      mm_rdata_r <= nxt_mm_rdata_s;
      busy_r     <= nxt_busy_s;
    end
  end

  assign ram_addr = ram_addr_r;
  assign ram_dout = ram_dout_r;
  assign ram_we   = ram_we_r;
  assign if_done  = if_done_r;
  assign mm_done  = mm_done_r;
  assign if_data  = if_data_r;
  assign mm_rdata = mm_rdata_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a behavioural byte RAM drives ram_din,
// and a transaction-level model (byte array + latency rules) predicts data,
// timing and RAM traffic for directed and randomized accesses.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_done;
  logic        mm_req;
  logic        mm_we;
  logic [1:0]  mm_len;
  logic [31:0] mm_addr;
  logic [31:0] mm_wdata;
  logic [31:0] mm_rdata;
  logic        mm_done;
  logic [7:0]  ram_din;
  logic [31:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_we;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mm_req(mm_req), .mm_we(mm_we), .mm_len(mm_len), .mm_addr(mm_addr),
    .mm_wdata(mm_wdata), .mm_rdata(mm_rdata), .mm_done(mm_done),
    .ram_din(ram_din), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .ram_we(ram_we), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // Synchronous byte RAM: write on strobe, read data one cycle after address
  always @(posedge clk) begin
    if (ram_we === 1'b1) ram[ram_addr] = ram_dout;
    ram_din <= ram_rd(ram_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a]     = b;
    ref_mem[a] = b;
  endtask

  function automatic int nbytes(input bit is_if, input logic [1:0] len);
    if (is_if) return 4;
    if (len == 2'd2) return 4;
    return int'(len) + 1;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) v |= {24'd0, ref_rd(a + 32'(i))} << (8 * i);
    return v;
  endfunction

  // Runs one access from an IDLE cycle and checks timing, traffic and data
  task automatic run_txn(input string tag, input bit is_if, input bit we,
                         input logic [1:0] len, input logic [31:0] addr,
                         input logic [31:0] wdata);
    int          n;
    int          done_cyc = 0;
    bit          traffic_ok = 1'b1;
    bit          other_done = 1'b0;
    logic [31:0] exp_data;
    logic [31:0] obs_data = 32'd0;
    logic [31:0] sh;
    bit          mem_ok = 1'b1;
    n = nbytes(is_if, len);
    exp_data = we ? 32'd0 : ref_read(addr, n);
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      mm_req = 1'b1; mm_we = we; mm_len = len; mm_addr = addr; mm_wdata = wdata;
    end
    @(posedge clk); #1;
    for (int c = 1; c <= 12 && done_cyc == 0; c++) begin
      @(negedge clk);
      sh = wdata >> (8 * (c - 1));
      if (we) begin
        if (c <= n) begin
          if (ram_we !== 1'b1 || ram_addr !== addr + 32'(c - 1) || ram_dout !== sh[7:0])
            traffic_ok = 1'b0;
        end else if (ram_we !== 1'b0) traffic_ok = 1'b0;
      end else begin
        if (ram_we !== 1'b0) traffic_ok = 1'b0;
        if (c <= n && ram_addr !== addr + 32'(c - 1)) traffic_ok = 1'b0;
      end
      if (busy !== 1'b1) traffic_ok = 1'b0;
      if ((is_if ? mm_done : if_done) !== 1'b0) other_done = 1'b1;
      if ((is_if ? if_done : mm_done) === 1'b1) begin
        done_cyc = c;
        obs_data = is_if ? if_data : mm_rdata;
      end
      @(posedge clk); #1;
    end
    if_req = 1'b0;
    mm_req = 1'b0;
    check({tag, "_done_cycle"}, 32'(done_cyc), we ? 32'(n + 1) : 32'(n + 2));
    check({tag, "_data"}, obs_data, exp_data);
    check({tag, "_traffic"}, {31'd0, traffic_ok}, 32'd1);
    check({tag, "_other_done"}, {31'd0, other_done}, 32'd0);
    @(negedge clk);
    check({tag, "_idle_after"}, {busy, ram_we, mm_done, if_done}, 32'd0);
    if (we) begin
      for (int i = 0; i < n; i++) begin
        sh = wdata >> (8 * i);
        ref_mem[addr + 32'(i)] = sh[7:0];
      end
      for (int i = 0; i < n; i++)
        if (ram_rd(addr + 32'(i)) !== ref_rd(addr + 32'(i))) mem_ok = 1'b0;
      check({tag, "_ram_contents"}, {31'd0, mem_ok}, 32'd1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int mm_cyc;
    int if_cyc;
    bit seen_done;
    logic [31:0] mm_val;
    logic [31:0] if_val;
    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'd0;
    mm_req = 1'b0; mm_we = 1'b0; mm_len = 2'd0; mm_addr = 32'd0; mm_wdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {busy, ram_we, if_done, mm_done}, 32'd0);
    check("reset_ram_addr", ram_addr, 32'd0);
    check("reset_data", if_data | mm_rdata | {24'd0, ram_dout}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // IF word read
    preload(32'h1000, 8'h11); preload(32'h1001, 8'h22);
    preload(32'h1002, 8'h33); preload(32'h1003, 8'h44);
    run_txn("if_word", 1'b1, 1'b0, 2'd3, 32'h1000, 32'd0);

    // Simultaneous requests: MM served first, IF after one IDLE cycle
    preload(32'h4000, 8'hA0); preload(32'h4001, 8'hB1);
    preload(32'h4002, 8'hC2); preload(32'h4003, 8'hD3);
    mm_cyc = 0; if_cyc = 0; mm_val = 32'd0; if_val = 32'd0;
    mm_req = 1'b1; mm_we = 1'b0; mm_len = 2'd3; mm_addr = 32'h4000;
    if_req = 1'b1; if_addr = 32'h1000;
    @(posedge clk); #1;
    for (int c = 1; c <= 20 && if_cyc == 0; c++) begin
      @(negedge clk);
      if (mm_done === 1'b1) begin mm_cyc = c; mm_val = mm_rdata; end
      if (if_done === 1'b1) begin if_cyc = c; if_val = if_data; end
      @(posedge clk); #1;
      if (mm_cyc != 0) mm_req = 1'b0;
    end
    if_req = 1'b0;
    check("arb_mm_cycle", 32'(mm_cyc), 32'd6);
    check("arb_mm_data", mm_val, 32'hD3C2B1A0);
    check("arb_if_cycle", 32'(if_cyc), 32'd13);
    check("arb_if_data", if_val, 32'h44332211);
    @(posedge clk); #1;

    // MM half write, byte read, illegal length, wrapping word read
    run_txn("mm_half_wr", 1'b0, 1'b1, 2'd1, 32'h2001, 32'h0000BEEF);
    preload(32'h3003, 8'h9C);
    run_txn("mm_byte_rd", 1'b0, 1'b0, 2'd0, 32'h3003, 32'd0);
    run_txn("mm_len2_wr", 1'b0, 1'b1, 2'd2, 32'h3100, 32'hCAFEF00D);
    run_txn("mm_len2_rd", 1'b0, 1'b0, 2'd2, 32'h3100, 32'd0);
    preload(32'hFFFFFFFE, 8'h01); preload(32'hFFFFFFFF, 8'h02);
    preload(32'h00000000, 8'h03); preload(32'h00000001, 8'h04);
    run_txn("mm_wrap_rd", 1'b0, 1'b0, 2'd3, 32'hFFFFFFFE, 32'd0);

    // Reset in cycle 3 of a word write
    mm_req = 1'b1; mm_we = 1'b1; mm_len = 2'd3; mm_addr = 32'h5000; mm_wdata = 32'hA1B2C3D4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    mm_req = 1'b0;
    @(negedge clk);
    check("abort_outputs", {busy, ram_we, mm_done, if_done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mm_done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
    end
    check("abort_no_done", {31'd0, seen_done}, 32'd0);
    ref_mem[32'h5000] = 8'hD4;
    ref_mem[32'h5001] = 8'hC3;
    check("abort_bytes", {ram_rd(32'h5000), ram_rd(32'h5001), ram_rd(32'h5002), ram_rd(32'h5003)},
          {ref_rd(32'h5000), ref_rd(32'h5001), ref_rd(32'h5002), ref_rd(32'h5003)});
    @(posedge clk); #1;
    run_txn("post_abort_rd", 1'b0, 1'b0, 2'd3, 32'h5000, 32'd0);

    // Randomized mix of fetches, reads and writes
    for (int t = 0; t < 30; t++) begin
      bit          r_if;
      bit          r_we;
      logic [1:0]  r_len;
      logic [31:0] r_addr;
      r_if   = ($urandom % 3) == 0;
      r_we   = r_if ? 1'b0 : 1'($urandom);
      r_len  = 2'($urandom);
      r_addr = (($urandom % 4) == 0) ? 32'hFFFFFFFC + 32'($urandom % 4)
                                     : 32'h6000 + 32'($urandom % 48);
      run_txn($sformatf("rnd%0d", t), r_if, r_we, r_len, r_addr, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
